srio_wr_tx_engine: RTL and testbench

Parametrised SRIO write-request transmitter for the SRIO–PCIe bridge. It accepts one write command, pulls payload from one of `C_NUM_SRC` selectable 64-bit AXI-Stream sources, and emits HELLO-format SWRITE or NWRITE packets on the SRIO ireq channel. Transfers longer than one SRIO packet are split automatically, with address and TID advanced per packet. All ireq outputs are registered through a 2-entry skid buffer.

---
 rtl/srio_pkg.sv | 44 ++++
 rtl/srio_skid_buf.sv | 72 +++++++
 rtl/srio_wr_tx_engine.sv | 183 ++++++++++++++++++
 tb/tb_srio_wr_tx_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : srio_pkg
// Purpose : Shared constants, FSM state encoding and helper functions for the
//           SRIO write-request transmitter (HELLO-format ireq packets).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package srio_pkg;

   localparam logic [7:0] FTYPE_TTYPE_SWRITE = 8'h60;
   localparam logic [7:0] FTYPE_TTYPE_NWRITE = 8'h54;
   localparam logic       CRF                = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HEAD  = 2'd1,
      ST_DATA  = 2'd2,
      ST_DRAIN = 2'd3
   } wr_state_t;

   // HELLO header: {tid, ftype/ttype, rsvd, prio, crf, size, rsvd, addr}
   function automatic logic [63:0] build_header(
      input logic [7:0]  tid,
      input logic [7:0]  ftype_ttype,
      input logic [1:0]  prio,
      input logic [7:0]  size,
      input logic [31:0] addr
   );
      return {tid, ftype_ttype, 1'b0, prio, CRF, size, 4'b0000, addr};
   endfunction

   // Reverse byte order: byte 0 <-> byte 7, byte 1 <-> byte 6, ...
   function automatic logic [63:0] byte_swap64(input logic [63:0] d);
      logic [63:0] r;
      r = '0;
      for (int b = 0; b < 8; b++) begin
         r[8*b +: 8] = d[8*(7-b) +: 8];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/srio_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : srio_skid_buf
// Purpose : 2-entry registered AXI-Stream slice carrying 64-bit data + last.
//           Outputs come straight from registers; input acceptance depends
//           only on the registered occupancy, so there is no combinational
//           path from out_ready back to the producer.
// Ports   : aclk/aresetn      clock, async active-low reset
//           in_valid/in_data/in_last   write side (write ignored when full)
//           full/empty         occupancy flags
//           out_valid/out_ready/out_data/out_last   AXIS master side
// Revision: 1.0 - initial release
// ============================================================================
module srio_skid_buf (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        in_valid,
   input  logic [63:0] in_data,
   input  logic        in_last,
   output logic        full,
   output logic        empty,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        out_last
);

   logic [1:0]  r_count;
   logic [64:0] r_head;   // entry presented on the output
   logic [64:0] r_tail;   // second entry, valid only when r_count == 2
   logic        w_push;
   logic        w_pop;

   assign full      = (r_count == 2'd2);
   assign empty     = (r_count == 2'd0);
   assign w_push    = in_valid && !full;
   assign w_pop     = out_ready && !empty;
   assign out_valid = !empty;
   assign out_data  = r_head[63:0];
   assign out_last  = r_head[64];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_count <= 2'd0;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_head <= {in_last, in_data};
               else                 r_tail <= {in_last, in_data};
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               if (r_count == 2'd2) r_head <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_head <= {in_last, in_data};
               end else begin
                  r_head <= r_tail;
                  r_tail <= {in_last, in_data};
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/srio_wr_tx_engine.sv
`default_nettype none
// ============================================================================
// Module  : srio_wr_tx_engine
// Purpose : SRIO write-request transmitter. Accepts one write command, pulls
//           payload from a selected 64-bit AXIS source and emits SWRITE or
//           NWRITE packets on ireq, splitting long transfers into packets of
//           at most C_MAX_PKT_BEATS beats (address and TID advance per packet).
// Ports   : aclk/aresetn                  clock, async active-low reset
//           wr_start/src/ftype/beats/addr/tid   command (sampled in IDLE)
//           wr_busy/wr_done/wr_err        command status
//           s_axis_src_*                  C_NUM_SRC payload sources
//           m_axis_ireq_*                 registered SRIO ireq output
// Revision: 1.0 - initial release
// ============================================================================
module srio_wr_tx_engine
   import srio_pkg::*;
#(
   parameter int         C_NUM_SRC       = 2,
   parameter int         C_MAX_PKT_BEATS = 32,
   parameter int         C_LEN_W         = 16,
   parameter int         C_BYTE_SWAP     = 1,
   parameter logic [1:0] C_PRIO          = 2'b01,
   localparam int        SW              = (C_NUM_SRC > 1) ? $clog2(C_NUM_SRC) : 1
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   wr_start,
   input  logic [SW-1:0]          wr_src,
   input  logic                   wr_ftype,
   input  logic [C_LEN_W-1:0]     wr_beats,
   input  logic [31:0]            wr_addr,
   input  logic [7:0]             wr_tid,
   output logic                   wr_busy,
   output logic                   wr_done,
   output logic                   wr_err,
   input  logic [C_NUM_SRC-1:0]   s_axis_src_tvalid,
   output logic [C_NUM_SRC-1:0]   s_axis_src_tready,
   input  logic [64*C_NUM_SRC-1:0] s_axis_src_tdata,
   output logic                   m_axis_ireq_tvalid,
   input  logic                   m_axis_ireq_tready,
   output logic [63:0]            m_axis_ireq_tdata,
   output logic                   m_axis_ireq_tlast
);

   localparam int PKT_W = $clog2(C_MAX_PKT_BEATS) + 1;

   wr_state_t            r_state, w_next;
   logic [SW-1:0]        r_src;
   logic                 r_ftype;
   logic [C_LEN_W-1:0]   r_rem;       // beats not yet assigned to a packet
   logic [31:0]          r_addr;
   logic [7:0]           r_tid;
   logic [PKT_W-1:0]     r_pkt_cnt;   // beats left in the current packet
   logic                 r_rej;

   logic                 w_bad;
   logic [PKT_W-1:0]     w_pkt_beats;
   logic [PKT_W+2:0]     w_pkt_bytes;
   logic [7:0]           w_size;
   logic [63:0]          w_header;
   logic                 w_sel_valid;
   logic [63:0]          w_sel_data;
   logic [63:0]          w_beat;
   logic                 w_last_beat;
   logic                 w_src_hs;
   logic                 w_push;
   logic [64:0]          w_push_word;
   logic                 w_full;
   logic                 w_empty;

   assign w_bad       = (wr_beats == '0) || (int'(wr_src) >= C_NUM_SRC);
   assign w_pkt_beats = (r_rem >= C_LEN_W'(C_MAX_PKT_BEATS)) ? PKT_W'(C_MAX_PKT_BEATS)
                                                             : r_rem[PKT_W-1:0];
   assign w_pkt_bytes = {w_pkt_beats, 3'b000};
   assign w_size      = r_ftype ? 8'(w_pkt_bytes - 1'b1) : 8'h00;
   assign w_header    = build_header(r_tid,
                                     r_ftype ? FTYPE_TTYPE_NWRITE : FTYPE_TTYPE_SWRITE,
                                     C_PRIO, w_size, r_addr);
   assign w_beat      = (C_BYTE_SWAP != 0) ? byte_swap64(w_sel_data) : w_sel_data;
   assign w_last_beat = (r_pkt_cnt == PKT_W'(1));

   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_data  = '0;
      for (int i = 0; i < C_NUM_SRC; i++) begin
         if (r_src == SW'(i)) begin
            w_sel_valid = s_axis_src_tvalid[i];
            w_sel_data  = s_axis_src_tdata[64*i +: 64];
         end
      end
   end

   // Only the latched source ever sees ready, and only while in DATA.
   for (genvar i = 0; i < C_NUM_SRC; i++) begin : g_src_ready
      assign s_axis_src_tready[i] = (r_state == ST_DATA) && (r_src == SW'(i)) && !w_full;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_push      = 1'b0;
      w_push_word = '0;
      w_src_hs    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (wr_start && !w_bad) w_next = ST_HEAD;
         end
         ST_HEAD: begin
            if (!w_full) begin
               w_push      = 1'b1;
               w_push_word = {1'b0, w_header};
               w_next      = ST_DATA;
            end
         end
         ST_DATA: begin
            w_src_hs = w_sel_valid && !w_full;
            if (w_src_hs) begin
               w_push      = 1'b1;
               w_push_word = {w_last_beat, w_beat};
               // r_rem was already reduced when this packet's header went out
               if (w_last_beat) w_next = (r_rem == '0) ? ST_DRAIN : ST_HEAD;
            end
         end
         ST_DRAIN: begin
            if (w_empty) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_src     <= '0;
         r_ftype   <= 1'b0;
         r_rem     <= '0;
         r_addr    <= '0;
         r_tid     <= '0;
         r_pkt_cnt <= '0;
         r_rej     <= 1'b0;
      end else begin
         r_rej <= (r_state == ST_IDLE) && wr_start && w_bad;
         if ((r_state == ST_IDLE) && wr_start && !w_bad) begin
            r_src   <= wr_src;
            r_ftype <= wr_ftype;
            r_rem   <= wr_beats;
            r_addr  <= wr_addr;
            r_tid   <= wr_tid;
         end
         // Per-packet bookkeeping advances as the header is committed.
         if ((r_state == ST_HEAD) && !w_full) begin
            r_pkt_cnt <= w_pkt_beats;
            r_rem     <= r_rem - C_LEN_W'(w_pkt_beats);
            r_addr    <= r_addr + 32'(w_pkt_bytes);
            r_tid     <= r_tid + 8'd1;
         end
         if (w_src_hs) r_pkt_cnt <= r_pkt_cnt - PKT_W'(1);
      end
   end

   assign wr_busy = (r_state != ST_IDLE);
   assign wr_done = ((r_state == ST_DRAIN) && w_empty) || r_rej;
   assign wr_err  = r_rej;

   srio_skid_buf u_skid (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .in_valid  (w_push),
      .in_data   (w_push_word[63:0]),
      .in_last   (w_push_word[64]),
      .full      (w_full),
      .empty     (w_empty),
      .out_valid (m_axis_ireq_tvalid),
      .out_ready (m_axis_ireq_tready),
      .out_data  (m_axis_ireq_tdata),
      .out_last  (m_axis_ireq_tlast)
   );

endmodule
`default_nettype wire

// File: tb/tb_srio_wr_tx_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_srio_wr_tx_engine
// Purpose : Self-checking bench for srio_wr_tx_engine. Table of commands with
//           a reference packet model, plus hand-written sequences for the
//           busy-ignore and reset-mid-packet cases.
// Revision: 1.0 - initial release
// ============================================================================
module tb_srio_wr_tx_engine;

   localparam int NS = 3;
   localparam int SW = 2;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   logic             wr_start = 1'b0;
   logic [SW-1:0]    wr_src = '0;
   logic             wr_ftype = 1'b0;
   logic [15:0]      wr_beats = '0;
   logic [31:0]      wr_addr = '0;
   logic [7:0]       wr_tid = '0;
   logic             wr_busy, wr_done, wr_err;
   logic [NS-1:0]    src_tvalid = '0;
   logic [NS-1:0]    src_tready;
   logic [64*NS-1:0] src_tdata;
   logic             ireq_tvalid, ireq_tlast;
   logic             ireq_tready = 1'b0;
   logic [63:0]      ireq_tdata;

   srio_wr_tx_engine #(
      .C_NUM_SRC(NS), .C_MAX_PKT_BEATS(32), .C_LEN_W(16),
      .C_BYTE_SWAP(1), .C_PRIO(2'b01)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .wr_start(wr_start), .wr_src(wr_src), .wr_ftype(wr_ftype),
      .wr_beats(wr_beats), .wr_addr(wr_addr), .wr_tid(wr_tid),
      .wr_busy(wr_busy), .wr_done(wr_done), .wr_err(wr_err),
      .s_axis_src_tvalid(src_tvalid), .s_axis_src_tready(src_tready),
      .s_axis_src_tdata(src_tdata),
      .m_axis_ireq_tvalid(ireq_tvalid), .m_axis_ireq_tready(ireq_tready),
      .m_axis_ireq_tdata(ireq_tdata), .m_axis_ireq_tlast(ireq_tlast)
   );

   // ---------------- payload sources ----------------
   function automatic logic [63:0] gen(input int i, input int n);
      logic [7:0]  ii;
      logic [31:0] nn;
      logic [15:0] m;
      ii = i[7:0];
      nn = n;
      m  = 16'(n * 3 + 7);
      return {ii, 8'hC3, m, nn};
   endfunction

   function automatic logic [63:0] swap(input logic [63:0] d);
      logic [63:0] r;
      for (int b = 0; b < 8; b++) r[8*b +: 8] = d[8*(7-b) +: 8];
      return r;
   endfunction

   int          src_cnt [NS] = '{default: 0};
   logic [NS-1:0] hs_flag = '0;
   int          cyc = 0;
   bit          rnd_valid = 1'b0;
   bit          rnd_ready = 1'b0;
   int          cur_src = -1;

   for (genvar g = 0; g < NS; g++) begin : g_src_data
      assign src_tdata[64*g +: 64] = gen(g, src_cnt[g]);
   end

   always @(posedge aclk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < NS; i++)
         if (hs_flag[i] && aresetn) src_cnt[i] <= src_cnt[i] + 1;
   end

   always @(posedge aclk) begin
      #1;
      for (int i = 0; i < NS; i++) begin
         if (src_tvalid[i] && !hs_flag[i]) src_tvalid[i] = 1'b1;
         else src_tvalid[i] = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      ireq_tready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
   end

   // ---------------- output monitor ----------------
   logic [64:0] rx[$];
   logic [64:0] exp_q[$];
   int          first_hs_cyc, last_tlast_cyc, done_cyc, start_cyc;
   bit          done_seen, done_err_seen, exp_err_cur;
   int          iso_viol, stall_viol;
   bit          prev_stall = 1'b0;
   logic [64:0] prev_word;

   always @(negedge aclk) begin
      hs_flag = aresetn ? (src_tvalid & src_tready) : '0;
      if (!aresetn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!ireq_tvalid || ({ireq_tlast, ireq_tdata} != prev_word)))
            stall_viol++;
         for (int j = 0; j < NS; j++)
            if (src_tready[j] && (j != cur_src)) iso_viol++;
         if (ireq_tvalid && ireq_tready) begin
            if (rx.size() == 0) first_hs_cyc = cyc;
            rx.push_back({ireq_tlast, ireq_tdata});
            if (ireq_tlast) last_tlast_cyc = cyc;
         end
         prev_stall = ireq_tvalid && !ireq_tready;
         prev_word  = {ireq_tlast, ireq_tdata};
         if (wr_done) begin
            done_seen     = 1'b1;
            done_err_seen = wr_err;
            done_cyc      = cyc;
         end
      end
   end

   // ---------------- checking helpers ----------------
   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, expv);
   endtask

   function automatic logic [64:0] rxw(input int i);
      if (i < rx.size()) return rx[i];
      return {65{1'bx}};
   endfunction

   task automatic model(input int src, input bit ft, input int beats,
                        input logic [31:0] addr, input logic [7:0] tid);
      int rem, k, n, base;
      logic [31:0] a;
      logic [7:0]  t, sz;
      rem = beats; k = 0; a = addr; t = tid; base = src_cnt[src];
      while (rem > 0) begin
         n  = (rem > 32) ? 32 : rem;
         sz = ft ? 8'(8 * n - 1) : 8'h00;
         exp_q.push_back({1'b0, t, (ft ? 8'h54 : 8'h60), 4'h2, sz, 4'h0, a});
         for (int j = 0; j < n; j++) begin
            exp_q.push_back({(j == n - 1), swap(gen(src, base + k))});
            k++;
         end
         rem = rem - n;
         a   = a + 32'(8 * n);
         t   = t + 8'd1;
      end
   endtask

   task automatic start_cmd(input int src, input bit ft, input int beats,
                            input logic [31:0] addr, input logic [7:0] tid,
                            input bit rr, input bit rv);
      rx.delete();
      exp_q.delete();
      done_seen = 1'b0; done_err_seen = 1'b0;
      iso_viol = 0; stall_viol = 0;
      first_hs_cyc = -1; last_tlast_cyc = -1; done_cyc = -1;
      exp_err_cur = (beats == 0) || (src >= NS);
      cur_src = exp_err_cur ? -1 : src;
      if (!exp_err_cur) model(src, ft, beats, addr, tid);
      rnd_ready = rr;
      rnd_valid = rv;
      @(posedge aclk); #1;
      wr_start = 1'b1; wr_src = src[SW-1:0]; wr_ftype = ft;
      wr_beats = 16'(beats); wr_addr = addr; wr_tid = tid;
      start_cyc = cyc;
      @(posedge aclk); #1;
      wr_start = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 3000 && !done_seen; k++) @(posedge aclk);
      repeat (3) @(posedge aclk);
      chk("done_seen", 65'(done_seen), 65'd1);
   endtask

   task automatic check_cmd(input bit rr, input int span);
      int n;
      chk("err_flag", 65'(done_err_seen), 65'(exp_err_cur));
      chk("word_count", 65'(rx.size()), 65'(exp_q.size()));
      n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk($sformatf("word%0d", i), rx[i], exp_q[i]);
      if (exp_err_cur) chk("rej_latency", 65'(done_cyc), 65'(start_cyc + 1));
      else             chk("done_latency", 65'(done_cyc), 65'(last_tlast_cyc + 1));
      if (!rr && !exp_err_cur) chk("hdr_latency", 65'(first_hs_cyc), 65'(start_cyc + 2));
      if (span >= 0) chk("span", 65'(last_tlast_cyc - first_hs_cyc), 65'(span));
      chk("src_isolation", 65'(iso_viol), 65'd0);
      chk("stall_stable", 65'(stall_viol), 65'd0);
      chk("busy_after_done", 65'(wr_busy), 65'd0);
   endtask

   typedef struct {
      int          src;
      bit          ft;
      int          beats;
      logic [31:0] addr;
      logic [7:0]  tid;
      bit          rr;
      bit          rv;
      int          span;
      int          tag;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 1'b0, 4,  32'h1000_0000, 8'h00, 1'b0, 1'b0, 4,  1};
      vecs[1] = '{1, 1'b1, 70, 32'h0000_2000, 8'h10, 1'b0, 1'b0, 72, 2};
      vecs[2] = '{1, 1'b1, 70, 32'h0000_2000, 8'h10, 1'b1, 1'b1, -1, 0};
      vecs[3] = '{0, 1'b0, 33, 32'hFFFF_FFF0, 8'hFF, 1'b1, 1'b1, -1, 0};
      vecs[4] = '{2, 1'b1, 1,  32'h0000_0008, 8'h07, 1'b0, 1'b0, 1,  0};
      vecs[5] = '{0, 1'b1, 32, 32'h0000_A000, 8'h55, 1'b1, 1'b1, -1, 0};
      vecs[6] = '{0, 1'b0, 0,  32'h0000_0100, 8'h01, 1'b0, 1'b0, -1, 0};
      vecs[7] = '{3, 1'b1, 8,  32'h0000_0200, 8'h02, 1'b0, 1'b0, -1, 0};

      repeat (3) @(posedge aclk); #1;
      chk("rst_ireq", {ireq_tvalid, ireq_tlast, ireq_tdata}, 65'd0);
      chk("rst_ctl", 65'({src_tready, wr_busy, wr_done, wr_err}), 65'd0);
      aresetn = 1'b1;
      repeat (2) @(posedge aclk);

      for (int v = 0; v < 8; v++) begin
         start_cmd(vecs[v].src, vecs[v].ft, vecs[v].beats, vecs[v].addr,
                   vecs[v].tid, vecs[v].rr, vecs[v].rv);
         wait_done();
         check_cmd(vecs[v].rr, vecs[v].span);
         if (vecs[v].tag == 1) begin
            chk("swrite_hdr", rxw(0), {1'b0, 64'h0060_2000_1000_0000});
            chk("swrite_beat0", rxw(1), {1'b0, 64'h0000_0000_0700_C300});
            chk("swrite_tlast", 65'(rxw(4)[64]), 65'd1);
         end
         if (vecs[v].tag == 2) begin
            chk("nw_hdr0", rxw(0),  {1'b0, 64'h1054_2FF0_0000_2000});
            chk("nw_hdr1", rxw(33), {1'b0, 64'h1154_2FF0_0000_2100});
            chk("nw_hdr2", rxw(66), {1'b0, 64'h1254_22F0_0000_2200});
            chk("nw_last0", 65'(rxw(32)[64]), 65'd1);
            chk("nw_last2", 65'(rxw(72)[64]), 65'd1);
         end
      end

      // start while busy must be ignored
      start_cmd(0, 1'b0, 4, 32'h0000_0300, 8'h20, 1'b0, 1'b0);
      repeat (2) @(posedge aclk); #1;
      wr_start = 1'b1; wr_src = 2'd1; wr_beats = 16'd5;
      @(posedge aclk); #1;
      wr_start = 1'b0;
      wait_done();
      check_cmd(1'b0, 4);
      done_seen = 1'b0;
      repeat (30) @(posedge aclk);
      chk("no_second_done", 65'(done_seen), 65'd0);
      chk("no_extra_words", 65'(rx.size()), 65'd5);

      // reset in the middle of a packet
      start_cmd(0, 1'b0, 32, 32'h0000_4000, 8'h30, 1'b0, 1'b0);
      for (int k = 0; k < 200 && rx.size() < 11; k++) @(negedge aclk);
      chk("reached_beat10", 65'(rx.size() >= 11), 65'd1);
      #1 aresetn = 1'b0;
      #1;
      chk("midrst_ireq", {ireq_tvalid, ireq_tlast, ireq_tdata}, 65'd0);
      chk("midrst_ctl", 65'({src_tready, wr_busy, wr_done, wr_err}), 65'd0);
      repeat (3) @(posedge aclk); #1;
      aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      start_cmd(0, 1'b1, 9, 32'h0000_5000, 8'h40, 1'b0, 1'b0);
      wait_done();
      check_cmd(1'b0, 9);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
